// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command front-end for the accumulator/ALU datapath.
// Commands are queued in a small FIFO. Each one is issued to the datapath as a
// single load pulse. After a settle window the accumulator, carry and zero flags
// are captured and returned on a valid/ready response port. A command with an
// illegal select code is answered with an error response and never reaches the
// datapath.
module alu_cmd_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 4,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     clb,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [SEL_W-1:0]         cmd_sel,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_carry,
    output logic                     rsp_z,
    output logic                     rsp_err,
    output logic [WIDTH-1:0]         dp_a,
    output logic [WIDTH-1:0]         dp_b,
    output logic [SEL_W-1:0]         dp_sel,
    output logic                     dp_load,
    input  logic [WIDTH-1:0]         dp_acc,
    input  logic                     dp_carry,
    input  logic                     dp_z,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    // DEPTH is a power of two (at least 2), so the pointers wrap on their own.
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int WC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(SETTLE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [SEL_W-1:0] SEL_ADD = SEL_W'(4'b0001);
    localparam logic [SEL_W-1:0] SEL_SUB = SEL_W'(4'b0010);
    localparam logic [SEL_W-1:0] SEL_NOR = SEL_W'(4'b0011);
    localparam logic [SEL_W-1:0] SEL_EQ  = SEL_W'(4'b0110);
    localparam logic [SEL_W-1:0] SEL_LT  = SEL_W'(4'b1000);
    localparam logic [SEL_W-1:0] SEL_SHL = SEL_W'(4'b1011);
    localparam logic [SEL_W-1:0] SEL_SHR = SEL_W'(4'b1100);

    logic [1:0]       state;
    logic [WC_W-1:0]  wait_cnt;
    logic             run;

    logic [WIDTH-1:0] mem_a   [DEPTH];
    logic [WIDTH-1:0] mem_b   [DEPTH];
    logic [SEL_W-1:0] mem_sel [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [SEL_W-1:0] head_sel;
    logic             head_legal;

    // Only the codes the datapath implements are forwarded to it.
    function automatic logic sel_legal(input logic [SEL_W-1:0] s);
        logic ok;
        case (s)
            SEL_ADD, SEL_SUB, SEL_NOR, SEL_EQ,
            SEL_LT, SEL_SHL, SEL_SHR: ok = 1'b1;
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Keep cmd_ready low while in reset and until the first edge after release.
    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign cmd_ready  = run && (count < FULL_CNT);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == S_IDLE) && (count != '0);

    assign head_a     = mem_a[rd_ptr];
    assign head_b     = mem_b[rd_ptr];
    assign head_sel   = mem_sel[rd_ptr];
    assign head_legal = sel_legal(head_sel);

    // Queue payload storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= cmd_a;
            mem_b[wr_ptr]   <= cmd_b;
            mem_sel[wr_ptr] <= cmd_sel;
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop leave count as is.
    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Command sequencing: pop, issue one load pulse, settle, capture, respond.
    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_sel    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_z     <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        if (head_legal) begin
                            dp_a   <= head_a;
                            dp_b   <= head_b;
                            dp_sel <= head_sel;
                            state  <= S_ISSUE;
                        end else begin
                            // Illegal code: answer directly, datapath untouched.
                            rsp_data  <= '0;
                            rsp_carry <= 1'b0;
                            rsp_z     <= 1'b0;
                            rsp_err   <= 1'b1;
                            state     <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        rsp_data  <= dp_acc;
                        rsp_carry <= dp_carry;
                        rsp_z     <= dp_z;
                        rsp_err   <= 1'b0;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dp_load    = (state == S_ISSUE);
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE) || (count != '0);
    assign fifo_count = count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed scenarios plus a randomized run, with
// an accumulator datapath model attached to each instance. Expected responses
// come from a plain-arithmetic model of the ALU operations.
module tb_alu_cmd_sequencer;

    localparam int W  = 8;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clb;

    // Instance with SETTLE = 1
    logic          cmd_valid, cmd_ready;
    logic [W-1:0]  cmd_a, cmd_b;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_carry, rsp_z, rsp_err;
    logic [W-1:0]  dp_a, dp_b;
    logic [SW-1:0] dp_sel;
    logic          dp_load;
    logic [W-1:0]  dp_acc = '0;
    logic          dp_carry = 1'b0;
    logic          dp_z;
    logic          busy;
    logic [2:0]    fifo_count;

    // Instance with SETTLE = 3
    logic          s3_valid, s3_ready;
    logic [W-1:0]  s3_a, s3_b;
    logic [SW-1:0] s3_sel;
    logic          s3_rsp_valid, s3_rsp_ready;
    logic [W-1:0]  s3_rsp_data;
    logic          s3_rsp_carry, s3_rsp_z, s3_rsp_err;
    logic [W-1:0]  s3_dp_a, s3_dp_b;
    logic [SW-1:0] s3_dp_sel;
    logic          s3_dp_load;
    logic [W-1:0]  s3_dp_acc = '0;
    logic          s3_dp_carry = 1'b0;
    logic          s3_dp_z;
    logic          s3_busy;
    logic [2:0]    s3_fifo_count;

    alu_cmd_sequencer #(.WIDTH(W), .SEL_W(SW), .DEPTH(4), .SETTLE(1)) u_dut (
        .clk(clk), .clb(clb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_load(dp_load),
        .dp_acc(dp_acc), .dp_carry(dp_carry), .dp_z(dp_z),
        .busy(busy), .fifo_count(fifo_count)
    );

    alu_cmd_sequencer #(.WIDTH(W), .SEL_W(SW), .DEPTH(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .clb(clb),
        .cmd_valid(s3_valid), .cmd_ready(s3_ready),
        .cmd_a(s3_a), .cmd_b(s3_b), .cmd_sel(s3_sel),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready),
        .rsp_data(s3_rsp_data), .rsp_carry(s3_rsp_carry), .rsp_z(s3_rsp_z), .rsp_err(s3_rsp_err),
        .dp_a(s3_dp_a), .dp_b(s3_dp_b), .dp_sel(s3_dp_sel), .dp_load(s3_dp_load),
        .dp_acc(s3_dp_acc), .dp_carry(s3_dp_carry), .dp_z(s3_dp_z),
        .busy(s3_busy), .fifo_count(s3_fifo_count)
    );

    // Reference response {err, z, carry, data[7:0]} from plain integer arithmetic.
    function automatic logic [10:0] ref_rsp(input int a, input int b, input int sel);
        int r;
        bit c;
        bit ok;
        ok = 1'b1;
        c  = 1'b0;
        r  = 0;
        case (sel)
            1:  begin r = a + b; c = (r > 255); end
            2:  begin r = a - b; c = (r < 0); end
            3:  r = 255 - (a | b);
            6:  r = (a == b) ? 1 : 0;
            8:  r = (a < b) ? 1 : 0;
            11: begin r = a * 2; c = (r > 255); end
            12: begin c = ((a % 2) == 1); r = a / 2; end
            default: ok = 1'b0;
        endcase
        r = (r + 512) % 256;
        if (!ok) return 11'h400;
        return {1'b0, (r == 0), c, r[7:0]};
    endfunction

    function automatic logic [8:0] dp_fn(input int a, input int b, input int sel);
        logic [10:0] t;
        t = ref_rsp(a, b, sel);
        return t[8:0];
    endfunction

    // Accumulator datapath models: register the ALU result on load_acc.
    always @(posedge clk) begin
        if (dp_load) {dp_carry, dp_acc} <= dp_fn(dp_a, dp_b, dp_sel);
        if (s3_dp_load) {s3_dp_carry, s3_dp_acc} <= dp_fn(s3_dp_a, s3_dp_b, s3_dp_sel);
    end
    assign dp_z    = (dp_acc == '0);
    assign s3_dp_z = (s3_dp_acc == '0);

    logic [19:0] exp_q[$];
    logic [10:0] obs_q[$];
    logic [19:0] iss_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    bit done     = 1'b0;
    bit [3:0] legal_tab [7] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd8, 4'd11, 4'd12};

    // Collect completed responses and issued datapath operations.
    always @(posedge clk) begin
        if (rsp_valid && rsp_ready) obs_q.push_back({rsp_err, rsp_z, rsp_carry, rsp_data});
        if (dp_load) iss_q.push_back({dp_sel, dp_b, dp_a});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    // One push attempt; called at a falling edge, returns at the next one.
    task automatic try_push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                            output bit ok);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        ok        = cmd_ready;
        if (ok) exp_q.push_back({sel, b, a});
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_wait(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 60) begin
            try_push(a, b, sel, ok);
            n++;
        end
        chk("push_accept", ok, 1);
    endtask

    task automatic wait_all();
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_count", obs_q.size(), exp_q.size());
    endtask

    task automatic compare_all();
        logic [19:0] e;
        logic [19:0] iss;
        logic [10:0] r;
        logic [10:0] o;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            r = ref_rsp(e[7:0], e[15:8], e[19:16]);
            chk("rsp", o, r);
            if (!r[10]) begin
                if (iss_q.size() > 0) iss = iss_q.pop_front();
                else iss = '1;
                chk("issued_op", iss, e);
            end
        end
        chk("no_extra_load", iss_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int lat;
        int ld_at;
        int nacc;
        clb = 1'b0;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; rsp_ready = 1'b1;
        s3_valid = 1'b0; s3_a = '0; s3_b = '0; s3_sel = '0; s3_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_dp_load", dp_load, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_dp_sel", dp_sel, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        clb = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        // Single add with latency measurement
        try_push(8'd15, 8'd10, 4'd1, ok);
        chk("t1_accept", ok, 1);
        lat = 0;
        ld_at = -1;
        while (!rsp_valid && lat < 20) begin
            if (dp_load && ld_at < 0) ld_at = lat;
            @(negedge clk);
            lat++;
        end
        chk("t1_rsp_latency", lat, 3);
        chk("t1_load_latency", ld_at, 1);
        chk("t1_rsp_data", rsp_data, 25);
        chk("t1_rsp_flags", {rsp_err, rsp_z, rsp_carry}, 0);
        chk("t1_dp_ops", {dp_sel, dp_b, dp_a}, {4'd1, 8'd10, 8'd15});
        wait_all();
        compare_all();

        // Back-to-back mix of operations
        push_wait(8'd20, 8'd25, 4'd2);
        push_wait(8'hAA, 8'h55, 4'd3);
        push_wait(8'h0F, 8'h00, 4'd11);
        push_wait(8'hF0, 8'h00, 4'd12);
        push_wait(8'd10, 8'd20, 4'd8);
        push_wait(8'd30, 8'd30, 4'd6);
        wait_all();
        chk("t2_sub", obs_q[0], 11'h1FB);
        chk("t2_nor", obs_q[1], 11'h200);
        chk("t2_shl", obs_q[2], 11'h01E);
        chk("t2_shr", obs_q[3], 11'h078);
        compare_all();

        // Illegal select code
        push_wait(8'h12, 8'h34, 4'hF);
        wait_all();
        chk("t3_no_load", iss_q.size(), 0);
        chk("t3_err_rsp", obs_q[0], 11'h400);
        chk("t3_dp_held", {dp_sel, dp_b, dp_a}, {4'd6, 8'd30, 8'd30});
        compare_all();
        push_wait(8'd7, 8'd9, 4'd1);
        wait_all();
        compare_all();

        // Backpressure: response stalled, queue fills
        rsp_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            try_push(8'(i * 17 + 3), 8'(i + 1), legal_tab[i % 7], ok);
            nacc += int'(ok);
        end
        chk("t4_accepted", nacc, 5);
        chk("t4_fifo_full", fifo_count, 4);
        chk("t4_ready_low", cmd_ready, 0);
        chk("t4_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        lat = 0;
        while (!cmd_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t4_ready_rise", lat, 2);
        chk("t4_count_after_pop", fifo_count, 3);
        wait_all();
        compare_all();

        // Reset while a command sits in WAIT with another queued
        try_push(8'd5, 8'd6, 4'd1, ok);
        try_push(8'd9, 8'd9, 4'd1, ok);
        @(negedge clk);
        chk("t5_in_wait", {busy, dp_load, rsp_valid}, 3'b100);
        clb = 1'b0;
        #1;
        chk("t5_rst_dp_load", dp_load, 0);
        chk("t5_rst_rsp_valid", rsp_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_count", fifo_count, 0);
        chk("t5_rst_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        clb = 1'b1;
        exp_q.delete();
        obs_q.delete();
        iss_q.delete();
        repeat (10) @(negedge clk);
        chk("t5_no_rsp", obs_q.size(), 0);
        chk("t5_no_load", iss_q.size(), 0);
        chk("t5_idle", busy, 0);
        push_wait(8'd1, 8'd1, 4'd1);
        wait_all();
        chk("t5_add_1_1", obs_q[0], 11'h002);
        compare_all();

        // SETTLE = 3 instance
        s3_valid = 1'b1; s3_a = 8'd200; s3_b = 8'd100; s3_sel = 4'd1;
        chk("t6_ready", s3_ready, 1);
        @(negedge clk);
        s3_valid = 1'b0;
        lat = 0;
        ld_at = -1;
        while (!s3_rsp_valid && lat < 30) begin
            if (s3_dp_load && ld_at < 0) ld_at = lat;
            @(negedge clk);
            lat++;
        end
        chk("t6_rsp_latency", lat, 5);
        chk("t6_load_latency", ld_at, 1);
        chk("t6_rsp", {s3_rsp_err, s3_rsp_z, s3_rsp_carry, s3_rsp_data}, 11'h12C);

        // Randomized commands with random response backpressure
        fork
            begin
                logic [3:0] sel;
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) sel = 4'($urandom_range(0, 15));
                    else sel = legal_tab[$urandom_range(0, 6)];
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    push_wait(8'($urandom), 8'($urandom), sel);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                rsp_ready = 1'b1;
            end
        join
        wait_all();
        compare_all();
        chk("end_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
